// File: rtl/morse_message_sequencer.sv
// Purpose : buffer ASCII characters, encode each to a Morse pattern/length, hand them one at a
//           time to the LED signal block over start/done, and insert inter-letter/inter-word silence.
// Latency : a character captured into an idle, empty sequencer raises o_Start two clocks later.
// Backpressure: o_Char_Ready (FIFO not full) gates writes; i_Done from the signal block paces output.
//
// Ports:
//   i_Clock, i_Reset (async, active-high)
//   i_Char_Valid / i_Char[7:0] / o_Char_Ready : character write interface
//   o_Start, o_Morse_Pattern[4:0] (bit4 = first symbol, 1 = dash), o_Morse_Length[2:0], i_Done
//   o_Busy : characters buffered or a character/gap in progress
//
// Build option: define MORSE_SEQ_LOWERCASE_EN to encode 'a'-'z' as their uppercase letters;
// without it lowercase codes are discarded like any other unsupported code.

// Character FIFO. Pointers carry one extra wrap bit so full and empty are distinguishable.
module morse_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    input  logic             rd_pop,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come straight from the registered pointers, never from wr_vld.
    assign wr_rdy = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
    assign rd_vld = (wr_ptr != rd_ptr);
    assign wr_en  = wr_vld && wr_rdy;
    assign rd_en  = rd_pop && rd_vld;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module morse_message_sequencer #(
    parameter int UNIT_CYCLES      = 6250000,
    parameter int FIFO_DEPTH       = 8,
    parameter int LETTER_GAP_UNITS = 2,
    parameter int WORD_GAP_UNITS   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Char_Valid,
    input  logic [7:0] i_Char,
    output logic       o_Char_Ready,
    output logic       o_Start,
    output logic [4:0] o_Morse_Pattern,
    output logic [2:0] o_Morse_Length,
    input  logic       i_Done,
    output logic       o_Busy
);
    localparam int GAP_UNITS_MAX  = (LETTER_GAP_UNITS > WORD_GAP_UNITS) ? LETTER_GAP_UNITS : WORD_GAP_UNITS;
    localparam int GAP_CYCLES_MAX = GAP_UNITS_MAX * UNIT_CYCLES;
    localparam int GAP_W          = (GAP_CYCLES_MAX > 0) ? $clog2(GAP_CYCLES_MAX + 1) : 1;

    // GAP runs counter+1 cycles, so loading N-1 gives exactly N silent cycles.
    localparam logic [GAP_W-1:0] LETTER_GAP_LOAD = GAP_W'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] WORD_GAP_LOAD   = GAP_W'(WORD_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE         = 1;

    typedef struct packed {
        logic [4:0] pattern;
        logic [2:0] length;
    } morse_sym_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t     state;
    logic [GAP_W-1:0] gap_cnt;

    logic       fifo_vld;
    logic [7:0] head_dat;
    logic       fifo_pop;

    logic [7:0] enc_char;
    morse_sym_t enc_sym;
    logic       enc_is_sym;
    logic       enc_is_space;

    // The head is consumed in LOAD only; IDLE checks registered occupancy, so a character
    // written into an empty FIFO is never popped in its own write cycle.
    assign fifo_pop = (state == S_LOAD);

    morse_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .wr_vld  (i_Char_Valid),
        .wr_dat  (i_Char),
        .wr_rdy  (o_Char_Ready),
        .rd_pop  (fifo_pop),
        .rd_vld  (fifo_vld),
        .rd_dat  (head_dat)
    );

    // Head-of-FIFO lookup: patterns are left-aligned with unused low bits zero.
    always_comb begin
        enc_char = head_dat;
`ifdef MORSE_SEQ_LOWERCASE_EN
        if (head_dat >= 8'h61 && head_dat <= 8'h7A) enc_char = head_dat - 8'h20;
`endif
        enc_is_space = (enc_char == 8'h20);
        enc_is_sym   = 1'b1;
        enc_sym      = '0;
        case (enc_char)
            8'h41: enc_sym = {5'b01000, 3'd2};  // A .-
            8'h42: enc_sym = {5'b10000, 3'd4};  // B -...
            8'h43: enc_sym = {5'b10100, 3'd4};  // C -.-.
            8'h44: enc_sym = {5'b10000, 3'd3};  // D -..
            8'h45: enc_sym = {5'b00000, 3'd1};  // E .
            8'h46: enc_sym = {5'b00100, 3'd4};  // F ..-.
            8'h47: enc_sym = {5'b11000, 3'd3};  // G --.
            8'h48: enc_sym = {5'b00000, 3'd4};  // H ....
            8'h49: enc_sym = {5'b00000, 3'd2};  // I ..
            8'h4A: enc_sym = {5'b01110, 3'd4};  // J .---
            8'h4B: enc_sym = {5'b10100, 3'd3};  // K -.-
            8'h4C: enc_sym = {5'b01000, 3'd4};  // L .-..
            8'h4D: enc_sym = {5'b11000, 3'd2};  // M --
            8'h4E: enc_sym = {5'b10000, 3'd2};  // N -.
            8'h4F: enc_sym = {5'b11100, 3'd3};  // O ---
            8'h50: enc_sym = {5'b01100, 3'd4};  // P .--.
            8'h51: enc_sym = {5'b11010, 3'd4};  // Q --.-
            8'h52: enc_sym = {5'b01000, 3'd3};  // R .-.
            8'h53: enc_sym = {5'b00000, 3'd3};  // S ...
            8'h54: enc_sym = {5'b10000, 3'd1};  // T -
            8'h55: enc_sym = {5'b00100, 3'd3};  // U ..-
            8'h56: enc_sym = {5'b00010, 3'd4};  // V ...-
            8'h57: enc_sym = {5'b01100, 3'd3};  // W .--
            8'h58: enc_sym = {5'b10010, 3'd4};  // X -..-
            8'h59: enc_sym = {5'b10110, 3'd4};  // Y -.--
            8'h5A: enc_sym = {5'b11000, 3'd4};  // Z --..
            8'h30: enc_sym = {5'b11111, 3'd5};  // 0
            8'h31: enc_sym = {5'b01111, 3'd5};  // 1
            8'h32: enc_sym = {5'b00111, 3'd5};  // 2
            8'h33: enc_sym = {5'b00011, 3'd5};  // 3
            8'h34: enc_sym = {5'b00001, 3'd5};  // 4
            8'h35: enc_sym = {5'b00000, 3'd5};  // 5
            8'h36: enc_sym = {5'b10000, 3'd5};  // 6
            8'h37: enc_sym = {5'b11000, 3'd5};  // 7
            8'h38: enc_sym = {5'b11100, 3'd5};  // 8
            8'h39: enc_sym = {5'b11110, 3'd5};  // 9
            default: enc_is_sym = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state           <= S_IDLE;
            gap_cnt         <= '0;
            o_Start         <= 1'b0;
            o_Morse_Pattern <= '0;
            o_Morse_Length  <= '0;
            o_Busy          <= 1'b0;
        end else begin
            // Registered view of "work outstanding": drops one cycle after IDLE with nothing queued.
            o_Busy <= !((state == S_IDLE) && !fifo_vld);

            case (state)
                S_IDLE: begin
                    if (fifo_vld) state <= S_LOAD;
                end

                S_LOAD: begin
                    if (enc_is_sym) begin
                        o_Morse_Pattern <= enc_sym.pattern;
                        o_Morse_Length  <= enc_sym.length;
                        o_Start         <= 1'b1;
                        state           <= S_START;
                    end else if (enc_is_space && (WORD_GAP_UNITS > 0)) begin
                        gap_cnt <= WORD_GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        // Unsupported code (or zero-length word gap): already popped, nothing sent.
                        state <= S_IDLE;
                    end
                end

                S_START: begin
                    if (i_Done) begin
                        o_Start <= 1'b0;
                        state   <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    // Wait for the signal block to drop done so the next start is seen as new.
                    if (!i_Done) begin
                        if (LETTER_GAP_UNITS > 0) begin
                            gap_cnt <= LETTER_GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - GAP_ONE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_message_sequencer.sv
`timescale 1ns/1ps
module tb_morse_message_sequencer;
    localparam int UNIT_CYCLES      = 4;
    localparam int FIFO_DEPTH       = 8;
    localparam int LETTER_GAP_UNITS = 2;
    localparam int WORD_GAP_UNITS   = 4;
    localparam int LETTER_GAP       = LETTER_GAP_UNITS * UNIT_CYCLES;
    localparam int WORD_GAP         = WORD_GAP_UNITS * UNIT_CYCLES;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic       i_Char_Valid;
    logic [7:0] i_Char;
    logic       o_Char_Ready;
    logic       o_Start;
    logic [4:0] o_Morse_Pattern;
    logic [2:0] o_Morse_Length;
    logic       i_Done;
    logic       o_Busy;

    morse_message_sequencer #(
        .UNIT_CYCLES      (UNIT_CYCLES),
        .FIFO_DEPTH       (FIFO_DEPTH),
        .LETTER_GAP_UNITS (LETTER_GAP_UNITS),
        .WORD_GAP_UNITS   (WORD_GAP_UNITS)
    ) dut (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .i_Char_Valid    (i_Char_Valid),
        .i_Char          (i_Char),
        .o_Char_Ready    (o_Char_Ready),
        .o_Start         (o_Start),
        .o_Morse_Pattern (o_Morse_Pattern),
        .o_Morse_Length  (o_Morse_Length),
        .i_Done          (i_Done),
        .o_Busy          (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // ---------------- reference model: Morse as dot/dash strings ----------------
    string let_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                            "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string dig_tab [10] = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

    function automatic string ref_code(input byte unsigned ch);
        if (ch >= 8'h41 && ch <= 8'h5A) return let_tab[ch - 8'h41];
`ifdef MORSE_SEQ_LOWERCASE_EN
        if (ch >= 8'h61 && ch <= 8'h7A) return let_tab[ch - 8'h61];
`endif
        if (ch >= 8'h30 && ch <= 8'h39) return dig_tab[ch - 8'h30];
        return "";
    endfunction

    typedef struct {
        logic [4:0] pattern;
        logic [2:0] length;
        int         spaces;   // word gaps queued ahead of this symbol
        int         drops;    // unsupported codes queued ahead of this symbol
        int         wcyc;     // last write cycle among this symbol and its predecessors
    } exp_t;

    exp_t exp_q[$];
    int   pend_spaces = 0;
    int   pend_drops  = 0;
    int   pend_wcyc   = 0;

    task automatic model_accept(input byte unsigned ch);
        string code;
        exp_t  e;
        if (ch == 8'h20) begin
            pend_spaces++;
            pend_wcyc = cyc;
        end else begin
            code = ref_code(ch);
            if (code.len() == 0) begin
                pend_drops++;
                pend_wcyc = cyc;
            end else begin
                e.pattern = '0;
                for (int i = 0; i < code.len(); i++)
                    if (code[i] == "-") e.pattern[4-i] = 1'b1;
                e.length = 3'(code.len());
                e.spaces = pend_spaces;
                e.drops  = pend_drops;
                e.wcyc   = cyc;
                exp_q.push_back(e);
                pend_spaces = 0;
                pend_drops  = 0;
            end
        end
    endtask

    // ---------------- behavioural LED signal block ----------------
    bit hold_done  = 0;
    int blk_phase  = 0;
    int blk_wait   = 0;
    int last_fall  = -1;
    int fall_cnt   = 0;

    initial begin
        i_Done = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (i_Reset) begin
                i_Done    = 1'b0;
                blk_phase = 0;
                last_fall = -1;
            end else begin
                case (blk_phase)
                    0: if (o_Start && !hold_done) begin blk_wait = $urandom_range(0, 3); blk_phase = 1; end
                    1: if (blk_wait == 0) begin i_Done = 1'b1; blk_phase = 2; end else blk_wait--;
                    2: if (!o_Start) begin blk_wait = $urandom_range(0, 2); blk_phase = 3; end
                    3: if (blk_wait == 0) begin
                           i_Done = 1'b0; last_fall = cyc; fall_cnt++; blk_phase = 0;
                       end else blk_wait--;
                    default: blk_phase = 0;
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int         starts_seen = 0;
    bit         prev_start  = 0;
    logic [4:0] cur_pat     = '0;
    logic [2:0] cur_len     = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge i_Clock);
            if (i_Reset) begin
                prev_start = 0;
            end else begin
                if (o_Start && !prev_start) begin
                    starts_seen++;
                    check("no_start_while_done", i_Done, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got pattern %b len %0d, expected no start", o_Morse_Pattern, o_Morse_Length);
                        cur_pat = o_Morse_Pattern;
                        cur_len = o_Morse_Length;
                    end else begin
                        e = exp_q.pop_front();
                        check("start_pattern", o_Morse_Pattern, e.pattern);
                        check("start_length", o_Morse_Length, e.length);
                        cur_pat = e.pattern;
                        cur_len = e.length;
                        // RELEASE sample + letter gap + IDLE + LOAD, plus any word gaps / discards between.
                        if (last_fall >= 0 && e.wcyc <= last_fall)
                            check("start_spacing", cyc - last_fall,
                                  3 + LETTER_GAP + e.spaces * (WORD_GAP + 2) + e.drops * 2);
                    end
                end
                if (!o_Start && prev_start) begin
                    check("pattern_held", o_Morse_Pattern, cur_pat);
                    check("length_held", o_Morse_Length, cur_len);
                end
                prev_start = o_Start;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_char(input byte unsigned ch, input bit expect_acc);
        check("char_ready", o_Char_Ready, expect_acc);
        i_Char_Valid = 1'b1;
        i_Char       = ch;
        if (expect_acc) model_accept(ch);
        @(negedge i_Clock);
    endtask

    task automatic write_when_ready(input byte unsigned ch);
        int n = 0;
        i_Char_Valid = 1'b0;
        while (!o_Char_Ready && n < 1000) begin @(negedge i_Clock); n++; end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 for %0d cycles, expected ready", n);
        end else begin
            i_Char_Valid = 1'b1;
            i_Char       = ch;
            model_accept(ch);
            @(negedge i_Clock);
            i_Char_Valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        i_Char_Valid = 1'b0;
        repeat (3) @(negedge i_Clock);
        while ((exp_q.size() != 0 || o_Busy || o_Start || i_Done) && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain_timeout: got %0d outstanding after %0d cycles, expected 0", name, exp_q.size(), n);
        end
        check({name, "_busy_idle"}, o_Busy, 0);
        pend_spaces = 0;
        pend_drops  = 0;
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        while (!o_Start && n < budget) begin @(negedge i_Clock); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_start_timeout: got no o_Start in %0d cycles, expected one", name, budget);
        end
    endtask

    byte unsigned bad_codes [8] = '{8'h23, 8'h21, 8'h00, 8'h7F, 8'h40, 8'h5B, 8'h2F, 8'h3A};

    initial begin
        string msg;
        int    s0;
        int    fc;
        int    n;
        int    tgt;
        int    exp_lc;

        i_Reset      = 1'b1;
        i_Char_Valid = 1'b0;
        i_Char       = 8'h00;

        // Reset state
        @(negedge i_Clock);
        check("rst_start", o_Start, 0);
        check("rst_pattern", o_Morse_Pattern, 0);
        check("rst_length", o_Morse_Length, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_ready", o_Char_Ready, 1);
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (2) @(negedge i_Clock);

        // "E": handshake, exact letter gap, then busy drops
        fc = fall_cnt;
        write_char(8'h45, 1);
        i_Char_Valid = 1'b0;
        n = 0;
        while (fall_cnt == fc && n < 200) begin @(negedge i_Clock); n++; end
        check("e_done_seen", (fall_cnt != fc) ? 1 : 0, 1);
        tgt = last_fall + LETTER_GAP;
        while (cyc < tgt) @(negedge i_Clock);
        check("e_busy_in_gap", o_Busy, 1);
        while (cyc < tgt + 2) @(negedge i_Clock);
        check("e_busy_after_gap", o_Busy, 0);
        wait_drain("e", 300);

        // "SOS"
        msg = "SOS";
        s0 = starts_seen;
        for (int i = 0; i < msg.len(); i++) write_char(msg[i], 1);
        wait_drain("sos", 500);
        check("sos_starts", starts_seen - s0, 3);

        // "A B": word gap between the letters
        msg = "A B";
        s0 = starts_seen;
        for (int i = 0; i < msg.len(); i++) write_char(msg[i], 1);
        wait_drain("a_b", 500);
        check("a_b_starts", starts_seen - s0, 2);

        // Fill the FIFO while stalled in START; ninth write must be refused
        hold_done = 1;
        s0 = starts_seen;
        write_char(8'h54, 1);
        i_Char_Valid = 1'b0;
        wait_start("stall", 50);
        msg = "KMNRUWDG5";
        for (int i = 0; i < msg.len(); i++) write_char(msg[i], (i < FIFO_DEPTH));
        i_Char_Valid = 1'b0;
        check("full_ready_low", o_Char_Ready, 0);
        check("full_busy", o_Busy, 1);
        repeat (5) @(negedge i_Clock);
        check("full_still_one_start", starts_seen - s0, 1);
        hold_done = 0;
        wait_drain("stall", 2000);
        check("stall_starts", starts_seen - s0, FIFO_DEPTH + 1);

        // Unsupported code, digit, lowercase
`ifdef MORSE_SEQ_LOWERCASE_EN
        exp_lc = 2;
`else
        exp_lc = 1;
`endif
        s0 = starts_seen;
        write_char(8'h23, 1);
        write_char(8'h37, 1);
        write_char(8'h61, 1);
        wait_drain("misc", 500);
        check("misc_starts", starts_seen - s0, exp_lc);

        // Full alphabet and digits through the ready handshake
        msg = "ABCDEFGHIJKLMNOPQRSTUVWXYZ 0123456789 az";
        for (int i = 0; i < msg.len(); i++) write_when_ready(msg[i]);
        wait_drain("alpha", 3000);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            byte unsigned ch;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: ch = 8'(8'h41 + $urandom_range(0, 25));
                5, 6:          ch = 8'(8'h30 + $urandom_range(0, 9));
                7:             ch = 8'h20;
                8:             ch = 8'(8'h61 + $urandom_range(0, 25));
                default:       ch = bad_codes[$urandom_range(0, 7)];
            endcase
            write_when_ready(ch);
            repeat ($urandom_range(0, 25)) @(negedge i_Clock);
        end
        wait_drain("rand", 5000);

        // Reset mid-START with three characters queued
        hold_done = 1;
        s0 = starts_seen;
        msg = "ETMI";
        for (int i = 0; i < msg.len(); i++) write_char(msg[i], 1);
        i_Char_Valid = 1'b0;
        wait_start("rst_mid", 50);
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b1;
        #1;
        check("rst_mid_start", o_Start, 0);
        check("rst_mid_busy", o_Busy, 0);
        check("rst_mid_ready", o_Char_Ready, 1);
        check("rst_mid_pattern", o_Morse_Pattern, 0);
        exp_q.delete();
        pend_spaces = 0;
        pend_drops  = 0;
        repeat (3) @(negedge i_Clock);
        i_Reset   = 1'b0;
        hold_done = 0;
        s0 = starts_seen;
        repeat (100) @(negedge i_Clock);
        check("rst_mid_no_send", starts_seen - s0, 0);
        check("rst_mid_idle", o_Busy, 0);

        // Recovery after reset
        write_char(8'h51, 1);
        wait_drain("recover", 300);
        check("recover_starts", starts_seen - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion by %0t, expected $finish", $time);
        $fatal(1, "global timeout");
    end
endmodule
